// File: rtl/multicycle_datapath_pkg.sv
// Shared definitions for the multicycle MIPS-subset datapath and its control unit.
package multicycle_datapath_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REG_IDX_W = 5;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_HOLD   = 2'b11;

    // R-format view of the instruction register
    typedef struct packed {
        logic [5:0]           opcode;
        logic [REG_IDX_W-1:0] rs;
        logic [REG_IDX_W-1:0] rt;
        logic [REG_IDX_W-1:0] rd;
        logic [4:0]           shamt;
        logic [5:0]           funct;
    } instr_t;

    function automatic logic [DATA_W-1:0] ext_imm16(input logic [15:0] imm, input logic zero_ext);
        return zero_ext ? {16'h0000, imm} : {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/multicycle_datapath_reg_file_2r1w.sv
// Register file: two combinational read ports, one synchronous write port, r0 reads zero.
module reg_file_2r1w
    import multicycle_datapath_pkg::*;
#(
    parameter int unsigned NREGS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] i_ra1,
    input  logic [REG_IDX_W-1:0] i_ra2,
    input  logic [REG_IDX_W-1:0] i_wa,
    input  logic [DATA_W-1:0]    i_wd,
    input  logic                 i_we,
    output logic [DATA_W-1:0]    o_rd1,
    output logic [DATA_W-1:0]    o_rd2
);

    logic [DATA_W-1:0] r_regs [NREGS];

    // Writes to index 0 are dropped so r0 stays at its reset value of zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_wa != '0)) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = (i_ra1 == '0) ? '0 : r_regs[i_ra1];
    assign o_rd2 = (i_ra2 == '0) ? '0 : r_regs[i_ra2];

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset datapath: executes one control word per clock against a
// unified combinational-read memory port.
module multicycle_datapath
    import multicycle_datapath_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned       NREGS    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemtoReg,
    input  logic              RegDst,
    input  logic              IorD,
    input  logic              ALUSrcA,
    input  logic              IRWrite,
    input  logic              MemWrite,
    input  logic              PCWrite,
    input  logic              RegWrite,
    input  logic              Ori,
    input  logic              Branch,
    input  logic [2:0]        ALUControl,
    input  logic [1:0]        ALUSrcB,
    input  logic [1:0]        PCSrc,
    output logic [5:0]        Opcode,
    output logic [5:0]        Funct,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [DATA_W-1:0] r_pc;
    instr_t            r_ir;
    logic [DATA_W-1:0] r_mdr;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_alu_out;

    logic [DATA_W-1:0]    w_ir_raw;
    logic [DATA_W-1:0]    w_rd1;
    logic [DATA_W-1:0]    w_rd2;
    logic [REG_IDX_W-1:0] w_wa;
    logic [DATA_W-1:0]    w_wd;
    logic [DATA_W-1:0]    w_imm;
    logic [DATA_W-1:0]    w_src_a;
    logic [DATA_W-1:0]    w_src_b;
    logic [DATA_W-1:0]    w_alu_result;
    logic                 w_zero;
    logic [DATA_W-1:0]    w_pc_next;
    logic                 w_pc_en;

    assign w_ir_raw = r_ir;

    reg_file_2r1w #(
        .NREGS (NREGS)
    ) u_reg_file (
        .clk   (clk),
        .rst   (rst),
        .i_ra1 (r_ir.rs),
        .i_ra2 (r_ir.rt),
        .i_wa  (w_wa),
        .i_wd  (w_wd),
        .i_we  (RegWrite),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2)
    );

    assign w_wa = RegDst ? r_ir.rd : r_ir.rt;
    assign w_wd = MemtoReg ? r_mdr : r_alu_out;

    assign w_imm   = ext_imm16(w_ir_raw[15:0], Ori);
    assign w_src_a = ALUSrcA ? r_a : r_pc;

    always_comb begin
        w_src_b = r_b;
        case (ALUSrcB)
            SRCB_REG:   w_src_b = r_b;
            SRCB_FOUR:  w_src_b = DATA_W'(4);
            SRCB_IMM:   w_src_b = w_imm;
            SRCB_IMMSH: w_src_b = {w_imm[DATA_W-3:0], 2'b00};
            default:    w_src_b = r_b;
        endcase
    end

    // ALU; undefined operation codes produce zero
    always_comb begin
        w_alu_result = '0;
        case (ALUControl)
            ALU_ADD: w_alu_result = w_src_a + w_src_b;
            ALU_SUB: w_alu_result = w_src_a - w_src_b;
            ALU_AND: w_alu_result = w_src_a & w_src_b;
            ALU_OR:  w_alu_result = w_src_a | w_src_b;
            ALU_SLT: w_alu_result = ($signed(w_src_a) < $signed(w_src_b)) ? DATA_W'(1) : '0;
            default: w_alu_result = '0;
        endcase
    end

    assign w_zero = (w_alu_result == '0);

    always_comb begin
        w_pc_next = r_pc;
        case (PCSrc)
            PC_ALU:    w_pc_next = w_alu_result;
            PC_ALUOUT: w_pc_next = r_alu_out;
            PC_JUMP:   w_pc_next = {r_pc[31:28], w_ir_raw[25:0], 2'b00};
            PC_HOLD:   w_pc_next = r_pc;
            default:   w_pc_next = r_pc;
        endcase
    end

    assign w_pc_en = PCWrite | (Branch & w_zero);

    // Architectural state; MDR/A/B/ALUOut reload every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_mdr     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu_out <= '0;
        end else begin
            r_mdr     <= mem_rdata;
            r_a       <= w_rd1;
            r_b       <= w_rd2;
            r_alu_out <= w_alu_result;
            if (IRWrite) begin
                r_ir <= instr_t'(mem_rdata);
            end
            if (w_pc_en) begin
                r_pc <= w_pc_next;
            end
        end
    end

    assign Opcode    = w_ir_raw[31:26];
    assign Funct     = w_ir_raw[5:0];
    assign mem_addr  = IorD ? r_alu_out : r_pc;
    assign mem_wdata = r_b;
    assign mem_we    = MemWrite;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: drives control words by hand and checks
// PC, ALUOut, B and register contents through the memory-side outputs.
module tb_multicycle_datapath;

    logic        clk;
    logic        rst;
    logic        MemtoReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite;
    logic        PCWrite, RegWrite, Ori, Branch;
    logic [2:0]  ALUControl;
    logic [1:0]  ALUSrcB, PCSrc;
    logic [5:0]  Opcode, Funct;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    int total = 0;
    int bad   = 0;
    logic [31:0] rv;

    multicycle_datapath dut (
        .clk        (clk),
        .rst        (rst),
        .MemtoReg   (MemtoReg),
        .RegDst     (RegDst),
        .IorD       (IorD),
        .ALUSrcA    (ALUSrcA),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .Ori        (Ori),
        .Branch     (Branch),
        .ALUControl (ALUControl),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .Opcode     (Opcode),
        .Funct      (Funct),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        MemtoReg = 0; RegDst = 0; IorD = 0; ALUSrcA = 0; IRWrite = 0; MemWrite = 0;
        PCWrite = 0; RegWrite = 0; Ori = 0; Branch = 0;
        ALUControl = 3'b000; ALUSrcB = 2'b00; PCSrc = 2'b00;
    endtask

    task automatic load_ir(input logic [31:0] instr);
        clr(); IRWrite = 1; mem_rdata = instr;
        cyc();
        clr();
    endtask

    // Loads IR with rt=idx, puts val into MDR, then writes it back through MemtoReg
    task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
        load_ir({6'h23, 5'd0, idx, 16'h0000});
        mem_rdata = val;
        cyc();
        clr(); RegWrite = 1; MemtoReg = 1;
        cyc();
        clr();
    endtask

    task automatic read_reg(input logic [4:0] idx, output logic [31:0] val);
        load_ir({6'h23, 5'd0, idx, 16'h0000});
        cyc();
        val = mem_wdata;
    endtask

    task automatic peek_alu_out(input string tag, input logic [31:0] exp);
        clr(); IorD = 1;
        #1;
        chk(tag, mem_addr, exp);
        clr();
    endtask

    task automatic exec_rr(input logic [2:0] ctrl, input string tag, input logic [31:0] exp);
        clr(); ALUSrcA = 1; ALUSrcB = 2'b00; ALUControl = ctrl;
        cyc();
        peek_alu_out(tag, exp);
    endtask

    task automatic ori_flow(input logic ori_bit, input string tag, input logic [31:0] exp);
        load_ir(32'h3408FFFF);
        cyc();
        ALUSrcA = 1; ALUSrcB = 2'b10; Ori = ori_bit; ALUControl = 3'b001;
        cyc();
        peek_alu_out({tag, "_aluout"}, exp);
        RegWrite = 1;
        cyc();
        clr();
        read_reg(5'd8, rv);
        chk({tag, "_r8"}, rv, exp);
    endtask

    initial begin
        clr();
        rst = 1'b1;
        mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_opcode", 32'(Opcode), 32'h0);
        chk("rst_funct", 32'(Funct), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // fetch with IR and PC loaded on the same edge
        IRWrite = 1; ALUSrcA = 0; ALUSrcB = 2'b01; ALUControl = 3'b010; PCSrc = 2'b00; PCWrite = 1;
        mem_rdata = 32'h014B4820;
        cyc();
        clr();
        #1;
        chk("fetch_pc", mem_addr, 32'h4);
        chk("fetch_opcode", 32'(Opcode), 32'h00);
        chk("fetch_funct", 32'(Funct), 32'h20);
        peek_alu_out("fetch_aluout", 32'h4);

        // same-edge write and read capture the old value
        write_reg(5'd15, 32'h11);
        mem_rdata = 32'h22;
        cyc();
        clr(); RegWrite = 1; MemtoReg = 1;
        cyc();
        clr();
        chk("no_bypass_old", mem_wdata, 32'h11);
        cyc();
        chk("no_bypass_new", mem_wdata, 32'h22);

        // R-type add $9 = $10 + $11
        write_reg(5'd10, 32'd7);
        write_reg(5'd11, 32'd5);
        load_ir(32'h014B4820);
        cyc();
        chk("add_b_rt", mem_wdata, 32'd5);
        exec_rr(3'b010, "add_aluout", 32'd12);
        RegDst = 1; RegWrite = 1;
        cyc();
        clr();
        read_reg(5'd9, rv);
        chk("add_r9", rv, 32'd12);
        chk("pc_after_add", mem_addr, 32'h4);

        write_reg(5'd0, 32'hCAFEF00D);
        write_reg(5'd0, 32'h00000001);
        read_reg(5'd0, rv);
        chk("r0_zero", rv, 32'h0);

        ori_flow(1'b1, "ori_zext", 32'h0000FFFF);
        ori_flow(1'b0, "ori_sext", 32'hFFFFFFFF);

        // beq taken: A=B=3, target 4 + (15<<2) = 0x40
        write_reg(5'd12, 32'd3);
        write_reg(5'd13, 32'd3);
        load_ir(32'h118D000F);
        ALUSrcA = 0; ALUSrcB = 2'b11; ALUControl = 3'b010;
        cyc();
        clr();
        #1;
        chk("pc_pre_branch", mem_addr, 32'h4);
        peek_alu_out("branch_target", 32'h40);
        ALUSrcA = 1; ALUControl = 3'b110; Branch = 1; PCSrc = 2'b01;
        cyc();
        clr();
        #1;
        chk("beq_taken_pc", mem_addr, 32'h40);

        // beq not taken: A=3, B=4
        write_reg(5'd13, 32'd4);
        load_ir(32'h118D000F);
        ALUSrcA = 0; ALUSrcB = 2'b11; ALUControl = 3'b010;
        cyc();
        peek_alu_out("branch_target2", 32'h7C);
        ALUSrcA = 1; ALUControl = 3'b110; Branch = 1; PCSrc = 2'b01;
        cyc();
        clr();
        #1;
        chk("beq_not_taken_pc", mem_addr, 32'h40);

        // ALU ops with A=3, B=-1
        write_reg(5'd13, 32'hFFFFFFFF);
        load_ir(32'h118D000F);
        cyc();
        exec_rr(3'b111, "slt_signed", 32'h0);
        exec_rr(3'b000, "and", 32'h3);
        exec_rr(3'b001, "or", 32'hFFFFFFFF);
        exec_rr(3'b110, "sub", 32'h4);
        exec_rr(3'b010, "add_wrap", 32'h2);
        exec_rr(3'b011, "undef_op", 32'h0);

        // lw $14, 0x100($0)
        load_ir(32'h8C0E0100);
        cyc();
        ALUSrcA = 1; ALUSrcB = 2'b10; ALUControl = 3'b010;
        cyc();
        IorD = 1; mem_rdata = 32'hDEADBEEF;
        #1;
        chk("lw_addr", mem_addr, 32'h100);
        cyc();
        clr(); MemtoReg = 1; RegWrite = 1;
        cyc();
        clr();
        read_reg(5'd14, rv);
        chk("lw_r14", rv, 32'hDEADBEEF);

        // sw $14, 0x100($0)
        load_ir(32'hAC0E0100);
        cyc();
        ALUSrcA = 1; ALUSrcB = 2'b10; ALUControl = 3'b010;
        cyc();
        IorD = 1; MemWrite = 1;
        #1;
        chk("sw_we", 32'(mem_we), 32'h1);
        chk("sw_addr", mem_addr, 32'h100);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        cyc();
        clr();
        #1;
        chk("sw_we_off", 32'(mem_we), 32'h0);

        // jump to word 0x40, then hold
        load_ir(32'h08000040);
        PCWrite = 1; PCSrc = 2'b10;
        cyc();
        clr();
        #1;
        chk("jump_pc", mem_addr, 32'h100);
        PCWrite = 1; PCSrc = 2'b11;
        cyc();
        clr();
        #1;
        chk("hold_pc", mem_addr, 32'h100);

        IRWrite = 1; PCWrite = 1; ALUSrcB = 2'b01; ALUControl = 3'b010;
        mem_rdata = 32'h0000002A;
        cyc();
        clr();
        #1;
        chk("fetch2_pc", mem_addr, 32'h104);
        chk("fetch2_funct", 32'(Funct), 32'h2A);

        // asynchronous reset away from a clock edge
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_mem_addr", mem_addr, 32'h0);
        chk("midrst_opcode", 32'(Opcode), 32'h0);
        chk("midrst_funct", 32'(Funct), 32'h0);
        chk("midrst_mem_we", 32'(mem_we), 32'h0);
        chk("midrst_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        read_reg(5'd14, rv);
        chk("midrst_r14", rv, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Multicycle MIPS-subset datapath; the consumer end of the control-signal interface driven by the control unit.
- Executes one control word per clock: memory addressing, IR/MDR/A/B/ALUOut latching, ALU operation, register write-back and PC update.
- Returns Opcode/Funct from the held instruction.
- Instruction/data memory is external, single unified port with combinational read.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NREGS, 32, register file depth (index width 5; register 0 hardwired to zero)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
MemtoReg  in  1  write-back source: 0 ALUOut, 1 MDR
RegDst  in  1  write-back index: 0 IR[20:16] (rt), 1 IR[15:11] (rd)
IorD  in  1  memory address: 0 PC, 1 ALUOut
ALUSrcA  in  1  ALU A operand: 0 PC, 1 A register
IRWrite  in  1  load IR from mem_rdata
MemWrite  in  1  memory write strobe
PCWrite  in  1  unconditional PC load
RegWrite  in  1  register file write enable
Ori  in  1  immediate zero-extend select
Branch  in  1  conditional PC load on Zero
ALUControl  in  3  ALU operation
ALUSrcB  in  2  ALU B operand select
PCSrc  in  2  next-PC select
Opcode  out  6  IR[31:26]
Funct  out  6  IR[5:0]
mem_addr  out  32  memory address
mem_wdata  out  32  store data (= B register)
mem_we  out  1  = MemWrite
mem_rdata  in  32  memory read data, valid same cycle as mem_addr

Behaviour:
- Reset (async, rst=1): PC<=RESET_PC; IR, MDR, A, B, ALUOut <= 0; all registers <= 0.
- After reset: Opcode=0, Funct=0, mem_addr=RESET_PC, mem_we=0.
- Reset mid-instruction: all state discarded and restart from RESET_PC. No partial register-file or PC write occurs on the edge where rst is asserted.
- Every cycle (unconditional): MDR<=mem_rdata; A<=reg[IR[25:21]]; B<=reg[IR[20:16]]; ALUOut<=ALUResult.
- IR<=mem_rdata only when IRWrite=1.
- mem_addr = IorD ? ALUOut : PC. Combinational; mem_we = MemWrite; mem_wdata = B.
- Immediate: Imm = Ori ? {16'h0, IR[15:0]} : sign-extend(IR[15:0]).
- SrcA = ALUSrcA ? A : PC.
- SrcB select: 00 B, 01 32'd4, 10 Imm, 11 Imm<<2.
- ALUControl encodings:
  - 010 add
  - 110 sub
  - 000 and
  - 001 or
  - 111 slt (signed, result 1/0)
  - all other codes: result 0.
- Arithmetic is 32-bit modulo; no overflow trap.
- Zero = (ALUResult == 0). Combinational.
- Next-PC select:
  - PCSrc 00: ALUResult
  - 01: ALUOut
  - 10: {PC[31:28], IR[25:0], 2'b00}
  - 11: PC (hold).
- PC load enable: PCEn = PCWrite | (Branch & Zero).
- Register write: when RegWrite=1, reg[wa] <= (MemtoReg ? MDR : ALUOut) at the clock edge.
  - Writes to index 0 are ignored; reads of index 0 return 0.
- Register read is combinational.
- Same-cycle write and read of one index: A/B capture the old value. No bypass.
- Opcode and Funct are combinational from IR.
- Simultaneous IRWrite and PCWrite is legal: IR gets mem_rdata at the old PC.

Decomposition:
- Shared package holds:
  - ALU_ADD/SUB/AND/OR/SLT 3-bit constants
  - SRCB_REG/FOUR/IMM/IMMSH constants
  - PC_ALU/ALUOUT/JUMP/HOLD constants
  - data width 32 and register index width 5.
- The control unit imports the same package.
- One natural sub-module: reg_file_2r1w.
  - Two combinational read ports, one synchronous write port.
  - Async reset, register 0 hardwired to zero.
- ALU stays inline.

Test Plan:
- Reset: assert rst mid-run -> PC=RESET_PC, mem_addr=0, Opcode=0, Funct=0, mem_we=0 immediately, before any clock edge.
- Fetch: mem_rdata=32'h014B4820, control word IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00, PCWrite=1 -> after one edge IR=32'h014B4820, PC=4, Opcode=6'h00, Funct=6'h20.
- R-type add: preload $10=7, $11=5 via write-back. Step decode, then execute (ALUSrcA=1, ALUSrcB=00, ALU_ADD), then write-back (RegDst=1, MemtoReg=0, RegWrite=1) -> $9=12. A repeated write to $0 leaves $0 reading 0.
- ori zero-extend: IR=ori $8,$0,0xFFFF with Ori=1, ALUSrcB=10, ALU_OR -> $8=32'h0000FFFF. With Ori=0 the same flow gives 32'hFFFFFFFF.
- Branch: IR=beq, A=B=3, ALU_SUB, Branch=1, PCSrc=01, ALUOut=0x40 -> PC=0x40. Then A=3, B=4 -> PC unchanged.
- lw/sw: IorD=1, ALUOut=0x100, mem_rdata=32'hDEADBEEF, MemtoReg=1, RegWrite=1, RegDst=0 -> rt=32'hDEADBEEF. Then MemWrite=1 -> mem_we=1, mem_addr=0x100, mem_wdata=B.
